// File: rtl/phase_shift_pkg.sv
// phase_shift_pkg: shared defaults, channel state encoding and effective divide/high helper
package phase_shift_pkg;
  localparam int DEF_DIVIDE = 2;
  localparam int DEF_HIGH = 1;
  localparam int DEF_PHASE = 0;
  typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_RUN} state_e;
  typedef struct packed {
    int unsigned d_eff;
    int unsigned h_eff;
  } eff_t;
  function automatic eff_t calc_eff(int unsigned d, int unsigned h);
    eff_t e;
    e.d_eff = (d == 32'd0) ? 32'd1 : d;
    e.h_eff = (h < e.d_eff) ? h : e.d_eff;
    return e;
  endfunction
endpackage

// File: rtl/phase_shift_channel.sv
// phase_shift_channel: one divided, phase-delayed output clock with period-count lock
module phase_shift_channel
  import phase_shift_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int LOCK_CYCLES = 2
) (
  input  logic             clk,
  input  logic             RST_N,
  input  logic             run_i,
  input  logic             align_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] div_i,
  input  logic [CNT_W-1:0] high_i,
  input  logic [CNT_W-1:0] phase_i,
  output logic             clk_out_o,
  output logic             lock_o
);
  localparam int PER_W = $clog2(LOCK_CYCLES + 1);
  logic [CNT_W-1:0] div_q, high_q, phase_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, dly_q, dly_d, d_eff, h_eff;
  logic [PER_W-1:0] per_q, per_d;
  state_e state_q, state_d;
  logic clk_q, clk_d, lock_q, lock_d, wrap;
  eff_t eff;
  assign eff = calc_eff(32'(div_q), 32'(high_q));
  assign d_eff = CNT_W'(eff.d_eff);
  assign h_eff = CNT_W'(eff.h_eff);
  assign wrap = cnt_q == d_eff - 1'b1;
  assign clk_out_o = clk_q;
  assign lock_o = lock_q;

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      div_q <= CNT_W'(DEF_DIVIDE);
      high_q <= CNT_W'(DEF_HIGH);
      phase_q <= CNT_W'(DEF_PHASE);
      state_q <= ST_IDLE;
      cnt_q <= '0;
      dly_q <= '0;
      per_q <= '0;
      clk_q <= 1'b0;
      lock_q <= 1'b0;
    end else begin
      if (wr_i) begin
        div_q <= div_i;
        high_q <= high_i;
        phase_q <= phase_i;
      end
      state_q <= state_d;
      cnt_q <= cnt_d;
      dly_q <= dly_d;
      per_q <= per_d;
      clk_q <= clk_d;
      lock_q <= lock_d;
    end
  end

  // Stopping beats alignment; alignment restarts from any state.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    dly_d = dly_q;
    per_d = per_q;
    if (!run_i) begin
      state_d = ST_IDLE;
      cnt_d = '0;
      dly_d = '0;
      per_d = '0;
    end else if (align_i) begin
      state_d = (phase_q == '0) ? ST_RUN : ST_DELAY;
      cnt_d = '0;
      dly_d = phase_q;
      per_d = '0;
    end else if (state_q == ST_DELAY) begin
      state_d = (dly_q <= CNT_W'(1)) ? ST_RUN : ST_DELAY;
      dly_d = dly_q - 1'b1;
      cnt_d = '0;
    end else if (state_q == ST_RUN) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
      per_d = (wrap && per_q != PER_W'(LOCK_CYCLES)) ? per_q + 1'b1 : per_q;
    end
  end

  always_comb begin
    clk_d = state_d == ST_RUN && cnt_d < h_eff;
    lock_d = state_d == ST_RUN && per_d == PER_W'(LOCK_CYCLES);
  end
endmodule

// File: rtl/phase_shift_bank.sv
// phase_shift_bank: NUM_CH phase-aligned divided clocks with config decode, align and lock
module phase_shift_bank
  import phase_shift_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W = 8,
  parameter int LOCK_CYCLES = 2
) (
  input  logic                                          clk,
  input  logic                                          RST_N,
  input  logic                                          PWRDWN,
  input  logic                                          en,
  input  logic                                          cfg_valid,
  output logic                                          cfg_ready,
  input  logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0]  cfg_ch,
  input  logic [CNT_W-1:0]                              cfg_divide,
  input  logic [CNT_W-1:0]                              cfg_high,
  input  logic [CNT_W-1:0]                              cfg_phase,
  output logic [NUM_CH-1:0]                             clk_out,
  output logic [NUM_CH-1:0]                             lock,
  output logic                                          locked_all
);
  logic cfg_ready_q, en_q, pd_q, trig_q, align_q, locked_all_q;
  logic run, acc, ch_ok, trig;
  assign run = en && !PWRDWN;
  assign acc = cfg_valid && cfg_ready_q;
  assign ch_ok = int'(cfg_ch) < NUM_CH;
  assign trig = run && ((acc && ch_ok) || !en_q || pd_q);
  assign cfg_ready = cfg_ready_q;
  assign locked_all = locked_all_q;

  // Triggers are captured, then re-qualified, so align lands one cycle later.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      cfg_ready_q <= 1'b0;
      en_q <= 1'b0;
      pd_q <= 1'b0;
      trig_q <= 1'b0;
      align_q <= 1'b0;
      locked_all_q <= 1'b0;
    end else begin
      cfg_ready_q <= !PWRDWN;
      en_q <= en;
      pd_q <= PWRDWN;
      trig_q <= trig;
      align_q <= trig_q && run;
      locked_all_q <= &lock;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    phase_shift_channel #(
      .CNT_W(CNT_W),
      .LOCK_CYCLES(LOCK_CYCLES)
    ) u_ch (
      .clk(clk),
      .RST_N(RST_N),
      .run_i(run),
      .align_i(align_q),
      .wr_i(acc && int'(cfg_ch) == i),
      .div_i(cfg_divide),
      .high_i(cfg_high),
      .phase_i(cfg_phase),
      .clk_out_o(clk_out[i]),
      .lock_o(lock[i])
    );
  end
endmodule

// File: tb/tb_phase_shift_bank.sv
// tb_phase_shift_bank: table-driven directed checks plus multi-cycle corner sequences
module tb_phase_shift_bank;
  logic clk = 1'b0, RST_N = 1'b0, PWRDWN = 1'b0, en = 1'b0, cfg_valid = 1'b0, v3 = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [7:0] cfg_divide = '0, cfg_high = '0, cfg_phase = '0;
  logic cfg_ready, locked_all, rdy3, la3;
  logic [3:0] clk_out, lock;
  logic [2:0] co3, lk3;
  int checks = 0, failures = 0, cyc = 0, e2c = 0;

  always #5 clk = ~clk;

  phase_shift_bank #(.NUM_CH(4), .CNT_W(8), .LOCK_CYCLES(2)) u_dut (
    .clk(clk), .RST_N(RST_N), .PWRDWN(PWRDWN), .en(en), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_divide(cfg_divide), .cfg_high(cfg_high),
    .cfg_phase(cfg_phase), .clk_out(clk_out), .lock(lock), .locked_all(locked_all)
  );

  phase_shift_bank #(.NUM_CH(3), .CNT_W(8), .LOCK_CYCLES(2)) u_dut3 (
    .clk(clk), .RST_N(RST_N), .PWRDWN(PWRDWN), .en(en), .cfg_valid(v3),
    .cfg_ready(rdy3), .cfg_ch(cfg_ch), .cfg_divide(cfg_divide), .cfg_high(cfg_high),
    .cfg_phase(cfg_phase), .clk_out(co3), .lock(lk3), .locked_all(la3)
  );

  typedef struct {
    logic en, v;
    logic [1:0] ch;
    logic [7:0] d, h, p;
    logic [3:0] co, lk;
    logic la;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic e, logic v, logic [1:0] ch, logic [7:0] d, logic [7:0] h,
                              logic [7:0] p, logic [3:0] co, logic [3:0] lk, logic la);
    vec_t r;
    r.en = e; r.v = v; r.ch = ch; r.d = d; r.h = h; r.p = p; r.co = co; r.lk = lk; r.la = la;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  task automatic wr_tick(input logic [1:0] ch, input logic [7:0] d, input logic [7:0] h,
                         input logic [7:0] p);
    cfg_valid = 1'b1; cfg_ch = ch; cfg_divide = d; cfg_high = h; cfg_phase = p;
    tick();
    cfg_valid = 1'b0;
  endtask

  initial begin
    // reset defaults with en rising at row 0, then en low, config writes, en rising at row 13
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 4'hF, 4'h0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 4'hF, 4'h0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 4'hF, 4'hF, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 4'h0, 4'hF, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1));
    tbl.push_back(mk(0, 1, 0, 4, 1, 0, 4'h0, 4'h0, 0));
    tbl.push_back(mk(0, 1, 1, 4, 3, 2, 4'h0, 4'h0, 0));
    tbl.push_back(mk(0, 1, 2, 2, 0, 0, 4'h0, 4'h0, 0));
    tbl.push_back(mk(0, 1, 3, 0, 5, 0, 4'h0, 4'h0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 4'b1001, 4'b0000, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 4'b1000, 4'b0000, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 4'b1010, 4'b1000, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 4'b1010, 4'b1000, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 4'b1011, 4'b1100, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 4'b1000, 4'b1100, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 4'b1010, 4'b1100, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 4'b1010, 4'b1100, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 4'b1011, 4'b1101, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 4'b1000, 4'b1101, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 4'b1010, 4'b1111, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 4'b1010, 4'b1111, 1));

    #2;
    chk("reset co", clk_out, 0);
    chk("reset lock", lock, 0);
    chk("reset la", locked_all, 0);
    chk("reset rdy", cfg_ready, 0);
    tick();
    tick();
    RST_N = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      en = tbl[i].en; cfg_valid = tbl[i].v; cfg_ch = tbl[i].ch;
      cfg_divide = tbl[i].d; cfg_high = tbl[i].h; cfg_phase = tbl[i].p;
      tick();
      if (i == 15) e2c = cyc;
      chk($sformatf("row%0d co", i), clk_out, tbl[i].co);
      chk($sformatf("row%0d lock", i), lock, tbl[i].lk);
      chk($sformatf("row%0d la", i), locked_all, tbl[i].la);
      chk($sformatf("row%0d rdy", i), cfg_ready, 1);
    end
    cfg_valid = 1'b0;

    // reconfigure ch0 while all locked
    wr_tick(0, 4, 2, 0);
    for (int k = 0; k <= 13; k++) begin
      if (k > 0) tick();
      if (k <= 1) chk($sformatf("recfg k%0d lock", k), lock, 4'hF);
      if (k == 2) chk("recfg align lock", lock, 4'h0);
      if (k == 2 || k == 3) chk($sformatf("recfg k%0d co", k), clk_out, 4'b1001);
      if (k == 4) chk("recfg k4 co", clk_out, 4'b1010);
      if (k == 9) chk("recfg k9 lock", lock, 4'b1100);
      if (k == 10) chk("recfg k10 lock", lock, 4'b1101);
      if (k == 13) chk("recfg la", locked_all, 1);
    end

    // out-of-range channel write on the 3-channel instance: no align, no change
    v3 = 1'b1; cfg_ch = 2'd3; cfg_divide = 8'd9; cfg_high = 8'd9; cfg_phase = 8'd9;
    tick();
    v3 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      chk($sformatf("badch k%0d lock", k), lk3, 3'b111);
      chk($sformatf("badch k%0d co", k), co3, ((cyc - e2c) % 2 == 0) ? 3'b111 : 3'b000);
    end
    chk("badch la", la3, 1);
    chk("badch rdy", rdy3, 1);

    // power-down mid-run, refused write, then automatic realign
    PWRDWN = 1'b1;
    tick();
    chk("pd co", clk_out, 0);
    chk("pd lock", lock, 0);
    chk("pd rdy", cfg_ready, 0);
    chk("pd la lag", locked_all, 1);
    cfg_valid = 1'b1; cfg_ch = 0; cfg_divide = 8'd2; cfg_high = 8'd2; cfg_phase = 8'd0;
    tick();
    cfg_valid = 1'b0;
    chk("pd2 rdy", cfg_ready, 0);
    chk("pd2 la", locked_all, 0);
    chk("pd2 co", clk_out, 0);
    PWRDWN = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      tick();
      if (k == 0) chk("pu rdy", cfg_ready, 1);
      chk($sformatf("pu k%0d co", k), clk_out, (k < 2) ? 4'b0000 : (k < 4) ? 4'b1001 : 4'b1010);
    end

    // async reset while ch1 sits in DELAY
    wr_tick(1, 4, 3, 5);
    tick();
    tick();
    tick();
    chk("predly co", clk_out, 4'b1001);
    #3;
    RST_N = 1'b0;
    #1;
    chk("arst co", clk_out, 0);
    chk("arst lock", lock, 0);
    chk("arst la", locked_all, 0);
    chk("arst rdy", cfg_ready, 0);
    #1;
    RST_N = 1'b1;
    for (int k = 0; k <= 7; k++) begin
      tick();
      chk($sformatf("post k%0d co", k), clk_out, (k >= 2 && k % 2 == 0) ? 4'hF : 4'h0);
      chk($sformatf("post k%0d lock", k), lock, (k >= 6) ? 4'hF : 4'h0);
      if (k == 7) chk("post la", locked_all, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
